// File: rtl/irq_pend_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Shared types and constants for the interrupt pending/acknowledge controller.
//   state_t    : controller FSM state encoding
//   IRQ_N      : number of request lines (matches encoder A width)
//   IRQ_IDW    : interrupt ID width (matches encoder Y width)
//   id_to_mask : one-hot vector selecting the pending bit for an ID
// ----------------------------------------------------------------------------
package irq_pkg;

    localparam int IRQ_N   = 8;
    localparam int IRQ_IDW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [IRQ_N-1:0] id_to_mask(input logic [IRQ_IDW-1:0] id);
        logic [IRQ_N-1:0] m;
        m     = '0;
        m[id] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/irq_pend_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_pend_ctrl_if
// Bundles the request lines, encoder hookup and CPU handshake of
// irq_pend_ctrl.
//   irq, mask          : raw request lines and per-line encode mask
//   pend_a             : masked pending vector toward the encoder A input
//   enc_valid, enc_y   : encoder result
//   int_req, int_id    : interrupt request / ID toward the CPU
//   int_ack, eoi       : CPU accept and end-of-interrupt pulses
//   pending            : raw pending register for status readback
// Modports: slave = controller side, master = environment (sources, encoder,
// CPU).
// ----------------------------------------------------------------------------
interface irq_pend_ctrl_if;
    import irq_pkg::*;

    logic [IRQ_N-1:0]   irq;
    logic [IRQ_N-1:0]   mask;
    logic [IRQ_N-1:0]   pend_a;
    logic               enc_valid;
    logic [IRQ_IDW-1:0] enc_y;
    logic               int_req;
    logic [IRQ_IDW-1:0] int_id;
    logic               int_ack;
    logic               eoi;
    logic [IRQ_N-1:0]   pending;

    modport slave (
        input  irq, mask, enc_valid, enc_y, int_ack, eoi,
        output pend_a, int_req, int_id, pending
    );

    modport master (
        output irq, mask, enc_valid, enc_y, int_ack, eoi,
        input  pend_a, int_req, int_id, pending
    );

endinterface

// File: rtl/irq_pend_ctrl_edge_cap.sv
// ----------------------------------------------------------------------------
// irq_edge_cap
// Rising-edge capture of request lines into a set/clear pending register.
//   clk, rst_n : clock, async active-low reset
//   irq        : raw request lines (level-held by sources)
//   clr        : per-bit retire request from the controller
//   pending    : captured pending bits
// A bit that sees a new rising edge on the same cycle it is retired stays
// set, so an edge arriving during the acknowledge is never lost.
// ----------------------------------------------------------------------------
module irq_edge_cap
    import irq_pkg::*;
#(
    parameter int N = IRQ_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq,
    input  logic [N-1:0] clr,
    output logic [N-1:0] pending
);

    logic [N-1:0] irq_d;
    logic [N-1:0] rise;

    assign rise = irq & ~irq_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d   <= '0;
            pending <= '0;
        end else begin
            irq_d   <= irq;
            pending <= (pending & ~clr) | rise;
        end
    end

endmodule

// File: rtl/irq_pend_ctrl.sv
// ----------------------------------------------------------------------------
// irq_pend_ctrl
// Interrupt pending/acknowledge controller placed around an external 8-input
// priority encoder. Request edges are latched into a pending register, the
// masked vector is handed to the encoder, and the encoder's choice is offered
// to the CPU with a request/acknowledge/end-of-interrupt handshake.
//   clk, rst_n : clock, async active-low reset
//   bus        : irq_pend_ctrl_if.slave (see interface header)
// Build option: IRQ_PREEMPT_EN lets a higher-priority source replace the
// offered ID while the request is still unacknowledged.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | no interrupt offered; waiting for encoder valid
//   REQ     | int_req high, int_id offered, waiting for int_ack
//   SERVICE | CPU servicing int_id, waiting for eoi
// ----------------------------------------------------------------------------
module irq_pend_ctrl
    import irq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    irq_pend_ctrl_if.slave  bus
);

    state_t             state_q;
    state_t             state_d;
    logic [IRQ_IDW-1:0] int_id_q;
    logic [IRQ_IDW-1:0] int_id_d;
    logic [IRQ_N-1:0]   clr;
    logic [IRQ_N-1:0]   pending;

    irq_edge_cap #(.N(IRQ_N)) u_edge_cap (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq     (bus.irq),
        .clr     (clr),
        .pending (pending)
    );

    assign bus.pending = pending;
    assign bus.pend_a  = pending & ~bus.mask;
    assign bus.int_id  = int_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            int_id_q <= '0;
        end else begin
            state_q  <= state_d;
            int_id_q <= int_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enc_valid) state_d = REQ;
            REQ:     if (bus.int_ack)   state_d = SERVICE;
            SERVICE: if (bus.eoi)       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        int_id_d    = int_id_q;
        clr         = '0;
        bus.int_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enc_valid) int_id_d = bus.enc_y;
            end
            REQ: begin
                bus.int_req = 1'b1;
                if (bus.int_ack) begin
                    // Retire the bit that was actually offered, even if its
                    // line has since been masked.
                    clr = id_to_mask(int_id_q);
                end
`ifdef IRQ_PREEMPT_EN
                else if (bus.enc_valid && (bus.enc_y > int_id_q)) begin
                    int_id_d = bus.enc_y;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
module tb_irq_pend_ctrl;
    import irq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_q[$];

    irq_pend_ctrl_if bus();

    irq_pend_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural stand-in for the 8-input priority encoder (MSB wins).
    always_comb begin
        bus.enc_valid = |bus.pend_a;
        bus.enc_y     = '0;
        for (int i = 0; i < IRQ_N; i++)
            if (bus.pend_a[i]) bus.enc_y = i[IRQ_IDW-1:0];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for int_req, then compare int_id against the scoreboard head.
    task automatic wait_req(input string tag);
        int n;
        int e;
        n = 0;
        while (bus.int_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'd0, bus.int_req}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_id"}, {29'd0, bus.int_id}, e);
        end
    endtask

    task automatic retire(input string tag);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        chk({tag, "_svc_req"}, {31'd0, bus.int_req}, 32'd0);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.irq     = '0;
        bus.mask    = '0;
        bus.int_ack = 1'b0;
        bus.eoi     = 1'b0;

        // ---- reset ----
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_int_req", {31'd0, bus.int_req}, 32'd0);
        chk("rst_int_id",  {29'd0, bus.int_id}, 32'd0);
        chk("rst_pending", {24'd0, bus.pending}, 32'h00);
        chk("rst_pend_a",  {24'd0, bus.pend_a}, 32'h00);

        // ---- multi-line priority ----
        bus.irq = 8'b1100_1110;
        exp_q.push_back(7); exp_q.push_back(6); exp_q.push_back(3);
        exp_q.push_back(2); exp_q.push_back(1);
        tick();
        chk("prio_pending", {24'd0, bus.pending}, 32'hCE);
        chk("prio_req_early", {31'd0, bus.int_req}, 32'd0);
        tick();
        chk("prio_req_lat", {31'd0, bus.int_req}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            wait_req("prio");
            retire("prio");
        end
        chk("prio_drained", {24'd0, bus.pending}, 32'h00);
        bus.irq = '0;
        repeat (2) tick();

        // ---- masking ----
        bus.mask = 8'h80;
        bus.irq  = 8'b1010_0110;
        exp_q.push_back(5);
        tick();
        chk("mask_pend_a", {24'd0, bus.pend_a}, 32'h26);
        tick();
        wait_req("mask_first");
        bus.mask = 8'h00;
        #1;
        chk("mask_unmask_pend_a", {24'd0, bus.pend_a}, 32'hA6);
        tick();
`ifdef IRQ_PREEMPT_EN
        chk("mask_preempt_id", {29'd0, bus.int_id}, 32'd7);
        exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(1);
`else
        chk("mask_frozen_id", {29'd0, bus.int_id}, 32'd5);
        exp_q.push_back(7); exp_q.push_back(2); exp_q.push_back(1);
`endif
        retire("mask");
        for (int i = 0; i < 3; i++) begin
            wait_req("mask");
            retire("mask");
        end
        chk("mask_drained", {24'd0, bus.pending}, 32'h00);
        bus.irq = '0;
        repeat (2) tick();

        // ---- set/clear collision ----
        bus.irq = 8'h04;
        exp_q.push_back(2);
        tick();
        tick();
        wait_req("coll_first");
        bus.irq = 8'h00;
        tick();
        bus.irq     = 8'h04;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        chk("coll_pending", {24'd0, bus.pending}, 32'h04);
        chk("coll_svc_req", {31'd0, bus.int_req}, 32'd0);
        bus.eoi = 1'b1;
        exp_q.push_back(2);
        tick();
        bus.eoi = 1'b0;
        wait_req("coll_again");
        retire("coll");
        chk("coll_drained", {24'd0, bus.pending}, 32'h00);
        bus.irq = '0;
        repeat (2) tick();

        // ---- stray handshake + held line ----
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        chk("stray_ack_req", {31'd0, bus.int_req}, 32'd0);
        chk("stray_ack_pend", {24'd0, bus.pending}, 32'h00);
        bus.irq = 8'h08;
        exp_q.push_back(3);
        tick();
        tick();
        wait_req("stray");
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("stray_eoi_req", {31'd0, bus.int_req}, 32'd1);
        chk("stray_eoi_pend", {24'd0, bus.pending}, 32'h08);
        retire("stray");
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.pending !== 8'h00 || bus.int_req !== 1'b0)
                chk("held_once", {23'd0, bus.int_req, bus.pending}, 32'h0);
        end
        chk("held_pending", {24'd0, bus.pending}, 32'h00);
        chk("held_req", {31'd0, bus.int_req}, 32'd0);
        bus.irq = '0;
        repeat (2) tick();

        // ---- async reset in SERVICE ----
        bus.irq = 8'h80;
        exp_q.push_back(7);
        tick();
        tick();
        wait_req("arst");
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.irq = 8'h8E;
        tick();
        chk("arst_pending", {24'd0, bus.pending}, 32'h0E);
        chk("arst_id_held", {29'd0, bus.int_id}, 32'd7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_int_req", {31'd0, bus.int_req}, 32'd0);
        chk("arst_int_id",  {29'd0, bus.int_id}, 32'd0);
        chk("arst_pending0", {24'd0, bus.pending}, 32'h00);
        chk("arst_pend_a",  {24'd0, bus.pend_a}, 32'h00);
        bus.irq = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, bus.int_req}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_pend_ctrl.md
Name: irq_pend_ctrl

Overview:
- Interrupt pending/acknowledge controller wrapped around the 8-input priority encoder (DIGIT_COM).
- Upstream side: captures rising edges on request lines into a pending register and drives the masked pending vector onto the encoder's A input.
- Downstream side: consumes the encoder's VALID/Y, presents one interrupt ID to the CPU with a request/acknowledge handshake, and retires the serviced bit.

Parameters:
- N, 8, number of request lines; matches the encoder input width.
- IDW, 3, ID width; equals log2(N) and matches the encoder Y width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IRQ  in  N  raw request lines, synchronous to CLK, level-held by sources.
- MASK  in  N  1 = line masked from encoding; pending bits are still captured.
- PEND_A  out  N  pending & ~MASK; drives encoder A.
- ENC_VALID  in  1  encoder VALID, combinational from PEND_A.
- ENC_Y  in  IDW  encoder Y; highest set bit index, MSB has highest priority.
- INT_REQ  out  1  interrupt request to CPU.
- INT_ID  out  IDW  ID of the requested/in-service interrupt; stable while INT_REQ=1 or in SERVICE.
- INT_ACK  in  1  one-cycle CPU accept pulse.
- EOI  in  1  one-cycle end-of-interrupt pulse.
- PENDING  out  N  raw pending register, for status readback.

Behaviour:
- Reset (RST_N=0, async): pending=0, irq_d=0, state=IDLE, INT_REQ=0, INT_ID=0, PEND_A=0, PENDING=0. Reset asserted mid-handshake abandons the interrupt with no retire.
- Edge capture: irq_d <= IRQ every cycle. Bit i of pending sets at an edge where IRQ[i]=1 and irq_d[i]=0. A held-high line sets its bit once only.
- Latency: IRQ high at edge k sets pending at edge k, giving PEND_A/ENC_VALID in cycle k. INT_REQ=1 after edge k+1.
- FSM, states IDLE, REQ, SERVICE:
  - IDLE: if ENC_VALID, then INT_ID <= ENC_Y, INT_REQ <= 1, go to REQ. Otherwise stay.
  - REQ: hold INT_REQ=1 and INT_ID. On INT_ACK: clear pending[INT_ID], INT_REQ <= 0, go to SERVICE.
  - SERVICE: INT_REQ=0, INT_ID held. On EOI: go to IDLE. A new request may issue on the edge after EOI at the earliest.
- INT_ACK outside REQ and EOI outside SERVICE are ignored.
- Simultaneous set and clear of the same bit: set wins, so the new edge stays pending.
- Masking a line while its ID sits in REQ does not withdraw the request. The ACK still clears that bit.
- Pending bits for masked lines accumulate. Unmasking exposes them on the same cycle through PEND_A.
- All pending=0 or all unmasked bits=0: ENC_VALID=0, FSM stays in IDLE.
- ENC_Y is don't-care when ENC_VALID=0 and is never sampled then.
- Widths: no arithmetic. INT_ID is always IDW bits; the index into pending is INT_ID, which is always in range.

Optional Feature:
- Macro IRQ_PREEMPT_EN.
- Defined: in REQ (before ACK), if ENC_VALID and ENC_Y > INT_ID, then INT_ID <= ENC_Y on that edge. INT_REQ stays 1 and the CPU acks the updated ID.
- Undefined: INT_ID is frozen from IDLE->REQ until ACK, and ENC_Y is ignored in REQ and SERVICE.

Decomposition:
- Package irq_pkg: state enum (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), IRQ_N=8, IRQ_IDW=3.
- Sub-module irq_edge_cap: the irq_d register plus rising-edge detect and the set/clear pending register with set priority. The FSM stays in the top module.
- The encoder is not instantiated inside the block. The bench connects the existing encoder between PEND_A and ENC_VALID/ENC_Y.

Test Plan:
- Reset check: RST_N=0 then 1 with IRQ=8'h00 -> INT_REQ=0, INT_ID=0, PENDING=8'h00, PEND_A=8'h00.
- Multi-line priority: IRQ=8'b11001110 in one cycle, MASK=0 -> PENDING=8'hCE, INT_REQ=1 with INT_ID=7 two edges later. After ACK+EOI the next issue is ID 6, then 3, 2, 1. PENDING reaches 8'h00 after five retires.
- Masking: IRQ=8'b10100110 with MASK=8'h80 -> first INT_ID=5. Clear MASK while in REQ -> ID stays 5 without the macro, becomes 7 with IRQ_PREEMPT_EN.
- Set/clear collision: in REQ with INT_ID=2, drop then re-raise IRQ[2] so its edge lands on the ACK edge -> PENDING[2] remains 1 and ID 2 issues again after EOI.
- Stray handshake: INT_ACK in IDLE and EOI in REQ -> no state change, PENDING unchanged. A held-high IRQ[3] is captured only once across 20 cycles.
- Async reset mid-operation: drop RST_N while in SERVICE with PENDING=8'h0E -> all outputs 0 immediately, without waiting for CLK.
